// File: rtl/four_digit_led_driver.sv
// four_digit_led_driver: scrolling 4-digit 7-seg viewer over a 16-char ROM.
// Define DEBOUNCE_EN to filter the button; otherwise raw synchronized edges count.
module four_digit_led_driver #(
  parameter int REFRESH_DIV     = 16,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic nxt_button,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [3:0] MSG [16] = '{
    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
    4'h8, 4'h9, 4'ha, 4'hb, 4'hc, 4'hd, 4'he, 4'hf
  };

  if (REFRESH_DIV < 2) begin : g_bad_div
    $error("REFRESH_DIV must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end

  function automatic logic [6:0] seg7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'ha:    s = 7'b0001000;
      4'hb:    s = 7'b1100000;
      4'hc:    s = 7'b0110001;
      4'hd:    s = 7'b1000010;
      4'he:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic          sync1;
  logic          sync2;
  logic          armed;
  logic          lvl_q;
  logic          rise;
  logic [3:0]    k;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    dig;
  logic [3:0]    idx;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;

`ifdef DEBOUNCE_EN
  logic [DW-1:0] db_cnt;
  logic          lvl;

  // level is accepted only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      lvl    <= 1'b0;
    end else if (sync2 == lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      lvl    <= sync2;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
`else
  logic lvl;
  assign lvl = sync2;
`endif

  assign rise = lvl & ~lvl_q & armed;

  // sync flops reset high so a button held through reset is not seen as a
  // fresh press; counting is armed only once the button is seen released
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      armed <= 1'b0;
      lvl_q <= 1'b0;
      k     <= 4'h0;
    end else begin
      sync1 <= nxt_button;
      sync2 <= sync1;
      armed <= armed | ~sync2;
      lvl_q <= lvl;
      if (rise) k <= k + 4'h1;
    end
  end

  assign idx = k + {2'b00, dig};

  // outputs are reloaded only at slot start, so K changes never tear a slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      dig      <= 2'd0;
      an_r     <= 4'hf;
      seg_r    <= 7'h7f;
    end else if (scan_cnt == '0) begin
      an_r     <= ~(4'b1000 >> dig);
      seg_r    <= seg7(MSG[idx]);
      scan_cnt <= SW'(1);
    end else if (scan_cnt == SW'(REFRESH_DIV - 1)) begin
      scan_cnt <= '0;
      dig      <= dig + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign {an3, an2, an1, an0} = an_r;
  assign {a, b, c, d, e, f, g} = seg_r;
  assign dp = 1'b1;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// tb_four_digit_led_driver: directed checks of scan order, segments,
// button stepping, wrap, hold/no-repeat and async reset behaviour.
module tb_four_digit_led_driver;

  localparam int RDIV = 16;
  localparam int DB   = 8;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DB;
`else
  localparam int LAT = 2;
`endif

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [3:0] ANP [4] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  logic clk = 1'b0;
  logic reset;
  logic nxt_button;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g;
  logic dp;
  logic [3:0] an;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;
  int exp_k  = 0;

  always #5 clk = ~clk;

  assign an  = {an3, an2, an1, an0};
  assign seg = {a, b, c, d, e, f, g};

  four_digit_led_driver #(
    .REFRESH_DIV    (RDIV),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .nxt_button(nxt_button),
    .an3       (an3),
    .an2       (an2),
    .an1       (an1),
    .an0       (an0),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .e         (e),
    .f         (f),
    .g         (g),
    .dp        (dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic press(input int hi, input int lo);
    nxt_button = 1'b1;
    repeat (hi) @(negedge clk);
    nxt_button = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic check_scan(input int kk);
    int n;
    n = 0;
    while (an == ANP[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (an != ANP[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("scan_start k%0d", kk), (n < 200), 1);
    for (int dd = 0; dd < 4; dd++) begin
      chk($sformatf("an k%0d d%0d", kk, dd), an, ANP[dd]);
      chk($sformatf("seg k%0d d%0d", kk, dd), seg, SEG[(kk + dd) % 16]);
      n = 0;
      while (an == ANP[dd] && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("slot_len k%0d d%0d", kk, dd), n, RDIV);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    nxt_button = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_an", an, 4'hf);
    chk("rst_seg", seg, 7'h7f);
    chk("rst_dp", dp, 1'b1);
    repeat (20) @(negedge clk);
    reset = 1'b0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("first_an", an, 4'b0111);
    chk("first_seg", seg, SEG[0]);
    check_scan(0);

    repeat (5) press(200, 200);
    exp_k = 5;
    check_scan(exp_k);

    repeat (3) press(200, 200);
    exp_k = 8;
    check_scan(exp_k);
    repeat (4) press(200, 200);
    exp_k = 12;
    check_scan(exp_k);
    repeat (4) press(200, 200);
    exp_k = 0;
    check_scan(exp_k);

    // long hold: latency, single step, dp constant
    @(negedge clk);
    nxt_button = 1'b1;
    repeat (LAT) @(posedge clk);
    #1;
    chk("lat_before", dut.k, exp_k);
    @(posedge clk);
    #1;
    exp_k = (exp_k + 1) % 16;
    chk("lat_after", dut.k, exp_k);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      chk("hold_dp", dp, 1'b1);
    end
    chk("hold_norepeat", dut.k, exp_k);
    nxt_button = 1'b0;
    repeat (200) @(negedge clk);
    check_scan(exp_k);

`ifdef DEBOUNCE_EN
    repeat (4) press(1, 1);
    press(100, 1);
    press(1, 1);
    press(1, 50);
    exp_k = (exp_k + 1) % 16;
    chk("glitch_k", dut.k, exp_k);
`else
    press(1, 3);
    press(1, 20);
    exp_k = (exp_k + 2) % 16;
    chk("bounce_k", dut.k, exp_k);
`endif
    check_scan(exp_k);

    while (exp_k != 7) begin
      press(200, 200);
      exp_k = (exp_k + 1) % 16;
    end
    check_scan(7);

    // async reset mid-display with a press in progress
    @(negedge clk);
    nxt_button = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_an", an, 4'hf);
    chk("async_seg", seg, 7'h7f);
    chk("async_dp", dp, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_k", dut.k, 0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    exp_k = 0;
    chk("held_thru_rst", dut.k, exp_k);
    check_scan(exp_k);
    nxt_button = 1'b0;
    repeat (50) @(negedge clk);
    chk("release_nocount", dut.k, exp_k);
    press(200, 200);
    exp_k = 1;
    check_scan(exp_k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
